sdram_dl_port: RTL and testbench

- Client-side initiator for one SDRAM controller request port, using the toggle req/ack protocol (port_req/port_ack, port_we, port_a[23:1], port_ds, port_d).
- Accepts the ROM-download byte stream (dl_wr/dl_addr/dl_data), packs bytes into 16-bit words with byte strobes, buffers them in a small FIFO, and issues one SDRAM write per word.
- Sits between the MiST data_io download interface and port1 of the SDRAM controller in each arcade top level.

---
 rtl/sdram_dl_pkg.sv | 23 ++
 rtl/sdram_dl_fifo.sv | 71 +++++++
 rtl/sdram_dl_port.sv | 253 +++++++++++++++++++++++++
 tb/tb_sdram_dl_port.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_dl_pkg.sv
// sdram_dl_pkg: shared types and constants for the SDRAM download port.
//   dl_entry_t : one packed SDRAM word write {word address, byte strobes, data}.
//   fsm_t      : request FSM states (RD_WAIT only reachable with SDRAM_DL_VERIFY_EN).
//   DS_*       : byte strobe encodings (bit0 = d[7:0], bit1 = d[15:8]).
package sdram_dl_pkg;

    typedef struct packed {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } dl_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
    } fsm_t;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

endpackage

// File: rtl/sdram_dl_fifo.sv
// sdram_dl_fifo: synchronous FIFO of dl_entry_t words.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i   : write request and word; ignored when full unless popping
//   pop_i            : remove head entry; ignored when empty
//   head_o           : current head entry (valid when empty_o = 0)
//   full_o, empty_o  : occupancy flags
// DEPTH must be a power of two, minimum 2, so the pointers wrap naturally.
module sdram_dl_fifo
    import sdram_dl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  dl_entry_t data_i,
    input  logic      pop_i,
    output dl_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dl_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_ok, pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/sdram_dl_port.sv
// sdram_dl_port: ROM-download initiator for one SDRAM controller port.
// Packs the data_io byte stream into 16-bit words with byte strobes, buffers
// them in a FIFO and issues one toggle req/ack write per word.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   dl_active, dl_wr,
//   dl_addr, dl_data            : download byte stream (dl_wr ignored when dl_active = 0)
//   port_req/port_ack           : toggle handshake; a request is outstanding while
//                                 port_req != port_ack, and port_we/a/ds/d are held
//                                 stable for that whole interval
//   port_we, port_a, port_ds,
//   port_d, port_q              : SDRAM port command, address, strobes, data
//   done                        : one-cycle pulse once a finished download is committed
//   overflow                    : sticky, a word was dropped (cleared on dl_active rise)
//   verify_err                  : sticky readback mismatch (cleared on dl_active rise)
// Optional: define SDRAM_DL_VERIFY_EN to read each word back after writing it and
// compare under its byte mask; otherwise port_q is unused and verify_err is 0.
module sdram_dl_port
    import sdram_dl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              port_req,
    input  logic              port_ack,
    output logic              port_we,
    output logic [22:0]       port_a,
    output logic [1:0]        port_ds,
    output logic [15:0]       port_d,
    input  logic [15:0]       port_q,
    output logic              done,
    output logic              overflow,
    output logic              verify_err
);

    // ---------------- dl_active edge detection ----------------
    logic act_q;
    logic act_rise, act_fall;

    assign act_rise = dl_active & ~act_q;
    assign act_fall = ~dl_active & act_q;

    // ---------------- byte packer ----------------
    logic        byte_v;
    logic [22:0] byte_wa;
    logic [1:0]  byte_ds;
    logic [15:0] byte_d;
    dl_entry_t   merged;
    dl_entry_t   pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        push;
    dl_entry_t   push_data;

    assign byte_v  = dl_wr & dl_active;
    assign byte_wa = 23'(dl_addr[ADDR_W-1:1]);
    assign byte_ds = dl_addr[0] ? DS_HI : DS_LO;
    assign byte_d  = dl_addr[0] ? {dl_data, 8'h00} : {8'h00, dl_data};

    always_comb begin
        merged.a  = pend_q.a;
        merged.ds = pend_q.ds | byte_ds;
        merged.d  = dl_addr[0] ? {dl_data, pend_q.d[7:0]} : {pend_q.d[15:8], dl_data};
    end

    always_comb begin
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        push      = 1'b0;
        push_data = pend_q;
        if (byte_v) begin
            if (pend_v_q && (pend_q.a == byte_wa)) begin
                // A word with both lanes filled has nothing more to wait for.
                if (merged.ds == DS_BOTH) begin
                    push      = 1'b1;
                    push_data = merged;
                    pend_v_d  = 1'b0;
                end else begin
                    pend_d = merged;
                end
            end else begin
                // Different word: flush the old one and start the new one together.
                push     = pend_v_q;
                pend_v_d = 1'b1;
                pend_d   = '{a: byte_wa, ds: byte_ds, d: byte_d};
            end
        end else if (act_fall && pend_v_q) begin
            push     = 1'b1;
            pend_v_d = 1'b0;
        end
    end

    // ---------------- FIFO ----------------
    dl_entry_t head;
    logic      fifo_full, fifo_empty;
    logic      pop;

    sdram_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- request FSM ----------------
    fsm_t        state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [22:0] a_q, a_d;
    logic [1:0]  ds_q, ds_d;
    logic [15:0] d_q, d_d;
    logic        ack_match;
    logic        verr_set;

    assign ack_match = (port_ack == req_q);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        a_d      = a_q;
        ds_d     = ds_q;
        d_d      = d_q;
        pop      = 1'b0;
        verr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    we_d    = 1'b1;
                    a_d     = head.a;
                    ds_d    = head.ds;
                    d_d     = head.d;
                    req_d   = ~req_q;
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (ack_match) begin
`ifdef SDRAM_DL_VERIFY_EN
                    // Read the same word back; the entry stays at the head until then.
                    we_d    = 1'b0;
                    ds_d    = DS_BOTH;
                    req_d   = ~req_q;
                    state_d = RD_WAIT;
`else
                    pop     = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef SDRAM_DL_VERIFY_EN
            RD_WAIT: begin
                if (ack_match) begin
                    pop      = 1'b1;
                    state_d  = IDLE;
                    verr_set = |((port_q ^ head.d) & {{8{head.ds[1]}}, {8{head.ds[0]}}});
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // ---------------- status flags ----------------
    logic ovf_q, ovf_d;
    logic armed_q, armed_d;
    logic done_q, done_cond;
    logic drop;

    assign drop      = push & fifo_full & ~pop;
    assign ovf_d     = (act_rise ? 1'b0 : ovf_q) | drop;
    assign done_cond = armed_q & ~dl_active & ~pend_v_q & fifo_empty &
                       (state_q == IDLE) & ack_match;

    // armed marks one high->low episode of dl_active still waiting for its done pulse.
    always_comb begin
        armed_d = armed_q;
        if (act_rise) begin
            armed_d = 1'b0;
        end else if (act_fall) begin
            armed_d = 1'b1;
        end else if (done_cond) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q    <= 1'b0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            a_q      <= '0;
            ds_q     <= '0;
            d_q      <= '0;
            ovf_q    <= 1'b0;
            armed_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            act_q    <= dl_active;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            a_q      <= a_d;
            ds_q     <= ds_d;
            d_q      <= d_d;
            ovf_q    <= ovf_d;
            armed_q  <= armed_d;
            done_q   <= done_cond;
        end
    end

`ifdef SDRAM_DL_VERIFY_EN
    logic verr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            verr_q <= 1'b0;
        end else begin
            verr_q <= (act_rise ? 1'b0 : verr_q) | verr_set;
        end
    end

    assign verify_err = verr_q;
`else
    logic unused_port_q;

    assign unused_port_q = ^{port_q, verr_set};
    assign verify_err    = 1'b0;
`endif

    assign port_req = req_q;
    assign port_we  = we_q;
    assign port_a   = a_q;
    assign port_ds  = ds_q;
    assign port_d   = d_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_sdram_dl_port.sv
// tb_sdram_dl_port: directed bench for sdram_dl_port with a toggle-ack responder
// (ack three cycles after each request) and a request monitor that checks every
// issued request against the expected queue.
module tb_sdram_dl_port;

    localparam int W = 42; // {we, a[22:0], ds[1:0], d[15:0]}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [23:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic        port_req;
    logic        port_ack = 1'b0;
    logic        port_we;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic [15:0] port_d;
    logic [15:0] port_q = '0;
    logic        done;
    logic        overflow;
    logic        verify_err;

    logic         ack_hold = 1'b0;
    logic         rd_corrupt = 1'b0;
    logic [W-1:0] exp_q[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           toggle_cnt = 0;
    int           done_cnt = 0;

    sdram_dl_port #(.FIFO_DEPTH(4), .ADDR_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .dl_active  (dl_active),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .port_req   (port_req),
        .port_ack   (port_ack),
        .port_we    (port_we),
        .port_a     (port_a),
        .port_ds    (port_ds),
        .port_d     (port_d),
        .port_q     (port_q),
        .done       (done),
        .overflow   (overflow),
        .verify_err (verify_err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- responder: ack 3 cycles after each toggle ----------------
    initial begin : responder
        int ack_cnt;
        ack_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                port_ack = 1'b0;
                ack_cnt  = 0;
            end else if (port_req !== port_ack && !ack_hold) begin
                ack_cnt++;
                if (ack_cnt == 3) begin
                    port_q   = rd_corrupt ? (port_d ^ 16'h0001) : port_d;
                    port_ack = port_req;
                    ack_cnt  = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic         last_req;
        logic [W-1:0] got, held, exp;
        last_req = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            got = {port_we, port_a, port_ds, port_d};
            if (reset) begin
                last_req = 1'b0;
            end else begin
                if (done === 1'b1) done_cnt++;
                if (port_req !== last_req) begin
                    last_req = port_req;
                    toggle_cnt++;
                    held = got;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_req: got %h, required no request", got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            miscompares++;
                            $display("FAIL req_fields: got %h, required %h", got, exp);
                        end
                    end
                end else if (port_req !== port_ack && got !== held) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL port_stable: got %h, required %h", got, held);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [23:0] addr, input logic [7:0] data);
        @(negedge clk);
        dl_wr   = 1'b1;
        dl_addr = addr;
        dl_data = data;
        @(negedge clk);
        dl_wr   = 1'b0;
    endtask

    task automatic exp_write(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
        exp_q.push_back({1'b1, a, ds, d});
`ifdef SDRAM_DL_VERIFY_EN
        exp_q.push_back({1'b0, a, 2'b11, d});
`endif
    endtask

    task automatic set_active(input logic v);
        @(negedge clk);
        dl_active = v;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || port_req !== port_ack) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d requests still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({port_req, port_we, port_a, port_ds, port_d, done, overflow, verify_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b we=%b a=%h ds=%b d=%h done=%b ovf=%b verr=%b, required all 0",
                     port_req, port_we, port_a, port_ds, port_d, done, overflow, verify_err);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pair_write;
        set_active(1'b1);
        exp_write(23'h0, 2'b11, 16'h2211);
        send_byte(24'h000, 8'h11);
        send_byte(24'h001, 8'h22);
        wait_drain(60);
        vectors++;
        if (port_req !== 1'b1) begin
            miscompares++;
            $display("FAIL pair_req_level: got %b, required 1", port_req);
        end
        done_cnt = 0;
        set_active(1'b0);
        repeat (10) @(negedge clk);
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL pair_done_count: got %0d, required 1", done_cnt);
        end
    endtask

    task automatic test_partial_flush;
        set_active(1'b1);
        exp_write(23'h2, 2'b10, 16'hAB00);
        send_byte(24'h005, 8'hAB);
        repeat (3) @(negedge clk);
        vectors++;
        if (toggle_cnt !== 1) begin
            miscompares++;
            $display("FAIL partial_held: got %0d toggles, required 1 (word must wait for dl_active fall)", toggle_cnt);
        end
        done_cnt = 0;
        set_active(1'b0);
        repeat (2) @(negedge clk);
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL partial_done_early: got %0d, required 0", done_cnt);
        end
        wait_drain(60);
        repeat (10) @(negedge clk);
        vectors++;
        if (done_cnt !== 1) begin
            miscompares++;
            $display("FAIL partial_done_count: got %0d, required 1", done_cnt);
        end
    endtask

    task automatic test_two_words;
        set_active(1'b1);
        exp_write(23'h8, 2'b01, 16'h0033);
        exp_write(23'h10, 2'b01, 16'h0044);
        send_byte(24'h010, 8'h33);
        send_byte(24'h020, 8'h44);
        set_active(1'b0);
        wait_drain(80);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL two_words_overflow: got %b, required 0", overflow);
        end
    endtask

    task automatic test_inactive_ignored;
        int t0;
        t0 = toggle_cnt;
        send_byte(24'h100, 8'h5A);
        send_byte(24'h101, 8'hA5);
        repeat (15) @(negedge clk);
        vectors++;
        if (toggle_cnt !== t0) begin
            miscompares++;
            $display("FAIL inactive_ignored: got %0d new toggles, required 0", toggle_cnt - t0);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] lo, hi;
        ack_hold = 1'b1;
        set_active(1'b1);
        // Head (in flight) plus three queued: words 0..3 survive, 4..11 are dropped.
        for (int i = 0; i < 4; i++) begin
            lo = 8'h40 + 8'(2 * i);
            hi = 8'h41 + 8'(2 * i);
            exp_write(23'h80 + 23'(i), 2'b11, {hi, lo});
        end
        for (int i = 0; i < 12; i++) begin
            lo = 8'h40 + 8'(2 * i);
            hi = 8'h41 + 8'(2 * i);
            send_byte(24'h100 + 24'(2 * i), lo);
            send_byte(24'h101 + 24'(2 * i), hi);
        end
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b, required 1", overflow);
        end
        ack_hold = 1'b0;
        set_active(1'b0);
        wait_drain(200);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: got %b, required 1", overflow);
        end
        set_active(1'b1);
        @(negedge clk);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got %b, required 0", overflow);
        end
        set_active(1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_in_flight;
        int n, t0;
        ack_hold = 1'b1;
        set_active(1'b1);
        exp_q.push_back({1'b1, 23'h200, 2'b11, 16'hBBAA});
        send_byte(24'h400, 8'hAA);
        send_byte(24'h401, 8'hBB);
        send_byte(24'h402, 8'hCC);
        send_byte(24'h403, 8'hDD);
        n = 0;
        while (port_req === port_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL rst_req_timeout: no request within 20 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({port_req, port_we, port_a, port_ds, port_d} !== '0) begin
            miscompares++;
            $display("FAIL rst_port_clear: got req=%b we=%b a=%h ds=%b d=%h, required all 0",
                     port_req, port_we, port_a, port_ds, port_d);
        end
        reset    = 1'b0;
        ack_hold = 1'b0;
        t0 = toggle_cnt;
        repeat (30) @(negedge clk);
        vectors++;
        if (toggle_cnt !== t0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_fifo_dropped: got %0d toggles and %0d pending, required 0 and 0",
                     toggle_cnt - t0, exp_q.size());
            exp_q.delete();
        end
        set_active(1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_verify;
        int t0;
        t0 = toggle_cnt;
        set_active(1'b1);
`ifdef SDRAM_DL_VERIFY_EN
        rd_corrupt = 1'b1;
`endif
        exp_write(23'h0, 2'b11, 16'h1234);
        send_byte(24'h000, 8'h34);
        send_byte(24'h001, 8'h12);
        wait_drain(80);
        rd_corrupt = 1'b0;
`ifdef SDRAM_DL_VERIFY_EN
        vectors++;
        if (verify_err !== 1'b1 || toggle_cnt - t0 !== 2) begin
            miscompares++;
            $display("FAIL verify_mismatch: got verr=%b toggles=%0d, required verr=1 toggles=2",
                     verify_err, toggle_cnt - t0);
        end
        set_active(1'b0);
        set_active(1'b1);
        @(negedge clk);
        vectors++;
        if (verify_err !== 1'b0) begin
            miscompares++;
            $display("FAIL verify_clear: got %b, required 0", verify_err);
        end
`else
        vectors++;
        if (verify_err !== 1'b0 || toggle_cnt - t0 !== 1) begin
            miscompares++;
            $display("FAIL verify_off: got verr=%b toggles=%0d, required verr=0 toggles=1",
                     verify_err, toggle_cnt - t0);
        end
`endif
        set_active(1'b0);
        repeat (5) @(negedge clk);
    endtask

    initial begin : main
        test_reset();
        test_pair_write();
        test_partial_flush();
        test_two_words();
        test_inactive_ignored();
        test_overflow();
        test_reset_in_flight();
        test_verify();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
